sm_key_debounce: RTL
====================

// Module: sm_key_debounce
// PURPOSE
//  Conditions the raw board keys and GPIO switches before they reach sm_top (clkEnable, memAddrB).
//  Per channel: 2-flop synchroniser, stability-counter debounce, one-cycle press/release pulses
//  and an optional hold-to-repeat strobe. Sits directly upstream of the core on the board top level.
// PARAMETERS
//  WIDTH          4          number of independent input channels
//  INVERT         1          1: raw input active-low (board keys); inverted before synchroniser
//  STABLE_CYCLES  1000000    consecutive cycles of a new level required to accept it (10 ms at 100 MHz), >=1
//  REPEAT_DELAY   50000000   cycles of continuous hold before first repeat strobe; 0 disables repeat
//  REPEAT_PERIOD  10000000   cycles between subsequent repeat strobes, >=1
// PORTS
//  clkIn     in   1      system clock
//  rst_n     in   1      asynchronous active-low reset
//  raw       in   WIDTH  unsynchronised key/switch inputs
//  state     out  WIDTH  debounced level, 1 = active (pressed / switch on)
//  press     out  WIDTH  one-cycle pulse when state goes 0->1
//  release   out  WIDTH  one-cycle pulse when state goes 1->0
//  strobe    out  WIDTH  press OR repeat pulse (single-cycle); feeds step/increment logic
// BEHAVIOUR
//  Reset (async assert, sync release by caller): sync flops, state, press, release, strobe, all counters = 0.
//  Synchroniser: s1 <= raw^{WIDTH{INVERT}}; s2 <= s1. All later logic uses s2 only.
//  Debounce counter dcnt[i] (width clog2(STABLE_CYCLES)+1, computed by internal function):
//   - s2==state: dcnt <= 0.
//   - s2!=state and dcnt < STABLE_CYCLES-1: dcnt <= dcnt+1.
//   - s2!=state and dcnt == STABLE_CYCLES-1: state <= s2, dcnt <= 0.
//   - Any glitch back to the old level before terminal count restarts the count from 0.
//   - Latency raw edge -> state edge: exactly 2+STABLE_CYCLES clkIn edges for a clean step.
//  press/release: registered, high in the same cycle state first shows the new value; low otherwise.
//  Repeat FSM per channel (rcnt width sized for max(REPEAT_DELAY,REPEAT_PERIOD)):
//   IDLE   : state==0. On state 0->1 -> HOLD, rcnt <= 0, strobe = press pulse.
//   HOLD   : rcnt++ each cycle; when rcnt==REPEAT_DELAY-1 -> RPT, strobe pulse, rcnt <= 0.
//   RPT    : rcnt++; when rcnt==REPEAT_PERIOD-1: strobe pulse, rcnt <= 0, stay.
//   HOLD/RPT: state 1->0 -> IDLE immediately (same edge as release); no strobe on release.
//   REPEAT_DELAY==0: FSM never leaves IDLE/HOLD-without-count; strobe == press.
//  First repeat strobe occurs REPEAT_DELAY cycles after the press cycle; then every REPEAT_PERIOD.
//  Channels fully independent; simultaneous events on several channels all reported in the same cycle.
//  Counters saturate-free: they never exceed terminal value, no wrap-around is possible.
//  Reset mid-count or mid-repeat: everything returns to 0/IDLE; a key still held after reset release
//   is re-debounced and produces a fresh press after 2+STABLE_CYCLES cycles.
// TESTING (bench params: WIDTH=4, INVERT=0, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  Clean step raw[0] 0->1 at edge N -> state[0]=1, press[0]=strobe[0]=1 for one cycle at edge N+6; others 0.
//  raw[1] bursts 1 for 3 cycles, 0 for 1, repeated 5x -> state[1] stays 0, no press/strobe pulses.
//  Hold raw[2]=1 for 30 cycles after accept -> strobe[2] at press, +10, +13, +16, ... ; release pulse once, no strobe.
//  raw[3:0] 0000->1111 on same edge -> all four press bits high in one cycle, state=4'hF.
//  rst_n low while raw[0] held in RPT -> all outputs 0 asynchronously; after rst_n high, press[0] 6 cycles later.
//  INVERT=1 instance, raw=4'hF idle, raw[0] driven 0 -> state[0]=1 after 6 cycles; reset value state=0.

Source files
------------

// File: rtl/sm_key_debounce.sv
// Key/switch conditioner: per-channel 2-flop synchroniser, stability-counter debounce,
// one-cycle press/release pulses and a hold-to-repeat strobe.
// The release pulse output is named 'released' because 'release' is a reserved word.
module sm_key_debounce #(
  parameter int unsigned WIDTH         = 4,
  parameter bit          INVERT        = 1'b1,
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input  logic             clkIn,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] released,
  output logic [WIDTH-1:0] strobe
);

  function automatic int unsigned clog2_f(input int unsigned v);
    for (int unsigned r = 0; r < 32; r++) begin
      if ((64'd1 << r) >= 64'(v)) return r;
    end
    return 32;
  endfunction

  localparam int unsigned DW     = clog2_f(STABLE_CYCLES) + 1;
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW     = clog2_f(RptMax) + 1;

  localparam logic [DW-1:0] DTerm      = DW'(STABLE_CYCLES - 1);
  localparam logic [DW-1:0] DOne       = DW'(1);
  localparam logic [RW-1:0] DelayTerm  = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] PeriodTerm = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] ROne       = RW'(1);
  localparam bit            RepeatEn   = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {StIdle, StHold, StRpt} rpt_st_e;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] press_q, rel_q, strobe_q;
  logic [WIDTH-1:0] rise, fall, rep;
  logic [DW-1:0]    dcnt_q [WIDTH];
  logic [DW-1:0]    dcnt_d [WIDTH];
  logic [RW-1:0]    rcnt_q [WIDTH];
  logic [RW-1:0]    rcnt_d [WIDTH];
  rpt_st_e          rpt_q  [WIDTH];
  rpt_st_e          rpt_d  [WIDTH];

  // Two-flop synchroniser; polarity normalised so 1 always means active.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw ^ {WIDTH{INVERT}};
      s2_q <= s1_q;
    end
  end

  // Debounce: a new level is accepted after STABLE_CYCLES consecutive differing samples.
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < WIDTH; i++) begin
      dcnt_d[i] = '0;
      if (s2_q[i] != state_q[i]) begin
        if (dcnt_q[i] == DTerm) state_d[i] = s2_q[i];
        else                    dcnt_d[i]  = dcnt_q[i] + DOne;
      end
    end
    rise = state_d & ~state_q;
    fall = state_q & ~state_d;
  end

  // Repeat FSM next state; a release always wins so no strobe accompanies it.
  always_comb begin
    rep = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rpt_d[i]  = rpt_q[i];
      rcnt_d[i] = rcnt_q[i];
      unique case (rpt_q[i])
        StIdle: begin
          rcnt_d[i] = '0;
          if (rise[i] && RepeatEn) rpt_d[i] = StHold;
        end
        StHold: begin
          if (fall[i]) begin
            rpt_d[i]  = StIdle;
            rcnt_d[i] = '0;
          end else if (rcnt_q[i] == DelayTerm) begin
            rpt_d[i]  = StRpt;
            rcnt_d[i] = '0;
            rep[i]    = 1'b1;
          end else begin
            rcnt_d[i] = rcnt_q[i] + ROne;
          end
        end
        StRpt: begin
          if (fall[i]) begin
            rpt_d[i]  = StIdle;
            rcnt_d[i] = '0;
          end else if (rcnt_q[i] == PeriodTerm) begin
            rcnt_d[i] = '0;
            rep[i]    = 1'b1;
          end else begin
            rcnt_d[i] = rcnt_q[i] + ROne;
          end
        end
        default: begin
          rpt_d[i]  = StIdle;
          rcnt_d[i] = '0;
        end
      endcase
    end
  end

  // State, counters and registered event pulses.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      strobe_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        dcnt_q[i] <= '0;
        rcnt_q[i] <= '0;
        rpt_q[i]  <= StIdle;
      end
    end else begin
      state_q  <= state_d;
      press_q  <= rise;
      rel_q    <= fall;
      strobe_q <= rise | rep;
      for (int i = 0; i < WIDTH; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        rcnt_q[i] <= rcnt_d[i];
        rpt_q[i]  <= rpt_d[i];
      end
    end
  end

  assign state    = state_q;
  assign press    = press_q;
  assign released = rel_q;
  assign strobe   = strobe_q;

endmodule
